// File: rtl/vis_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vis_pkg
//  Brief   : Shared screen geometry, coordinate widths and sequencer states
//            for the visualizer drawing sequencers.
//  Revision: 1.0
// ============================================================================
package vis_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;

    localparam logic signed [9:0] c_Y_MAX = 10'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RD1   = 3'd2,
        ST_RD2   = 3'd3,
        ST_ISSUE = 3'd4,
        ST_WAIT  = 3'd5,
        ST_FIN   = 3'd6
    } seq_state_t;

    // Saturate a 10-bit signed screen row into the visible range.
    function automatic logic [Y_W-1:0] clamp_y(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            return '0;
        end else if (v > c_Y_MAX) begin
            return c_Y_MAX[Y_W-1:0];
        end else begin
            return v[Y_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module  : sample_bank_ram
//  Brief   : Dual-bank sample store; writes go to the back bank, synchronous
//            reads come from the front bank selected by i_bank_sel.
//  Revision: 1.0
// ============================================================================
module sample_bank_ram #(
    parameter int NUM_POINTS = 32,
    parameter int AW         = 5
) (
    input  logic          clk,
    input  logic          i_bank_sel,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    localparam int c_DEPTH = 2 * NUM_POINTS;

    logic [7:0] r_mem [0:c_DEPTH-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{~i_bank_sel, i_waddr}] <= i_wdata;
        end
        r_rdata <= r_mem[{i_bank_sel, i_raddr}];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/waveform_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : waveform_line_sequencer
//  Brief   : Walks a double-buffered sample array and issues one line segment
//            per adjacent sample pair to the thick-line drawer (Go/Done).
//  Revision: 1.0
// ============================================================================
module waveform_line_sequencer
    import vis_pkg::*;
#(
    parameter int NUM_POINTS = 32,
    parameter int X_ORIGIN   = 5,
    parameter int X_STEP     = 10,
    parameter int Y_CENTER   = 120
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_we,
    input  logic [$clog2(NUM_POINTS)-1:0] sample_addr,
    input  logic [7:0]                    sample_data,
    input  logic [8:0]                    thickness_cfg,
    input  logic                          frame_start,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          Go,
    output logic [X_W-1:0]                X0,
    output logic [X_W-1:0]                X1,
    output logic [Y_W-1:0]                Y0,
    output logic [Y_W-1:0]                Y1,
    output logic [8:0]                    Thickness,
    input  logic                          Done
);

    localparam int AW = $clog2(NUM_POINTS);
    localparam logic signed [9:0] c_Y_CENTER = 10'(Y_CENTER);

    seq_state_t             r_state;
    logic                   r_bank_sel;
    logic                   r_pending;
    logic [AW-1:0]          r_idx;
    logic [X_W-1:0]         r_x_acc;

    logic [AW-1:0]          w_raddr;
    logic [7:0]             w_rdata;
    logic signed [9:0]      w_sample_ext;
    logic signed [9:0]      w_y_wide;
    logic [Y_W-1:0]         w_y;
    logic                   w_accept;
    logic                   w_last;

    sample_bank_ram #(
        .NUM_POINTS (NUM_POINTS),
        .AW         (AW)
    ) u_bank (
        .clk        (clk),
        .i_bank_sel (r_bank_sel),
        .i_we       (sample_we),
        .i_waddr    (sample_addr),
        .i_wdata    (sample_data),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata)
    );

    // RD1 prefetches the second endpoint of the segment.
    assign w_raddr      = (r_state == ST_RD1) ? (r_idx + AW'(1)) : r_idx;
    assign w_sample_ext = {{2{w_rdata[7]}}, w_rdata};
    assign w_y_wide     = c_Y_CENTER - w_sample_ext;
    assign w_y          = clamp_y(w_y_wide);
    assign w_accept     = (r_state == ST_IDLE) && (frame_start || r_pending);
    assign w_last       = (r_idx == AW'(NUM_POINTS - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bank_sel <= 1'b0;
            r_pending  <= 1'b0;
            r_idx      <= '0;
            r_x_acc    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            Go         <= 1'b0;
            X0         <= '0;
            X1         <= '0;
            Y0         <= '0;
            Y1         <= '0;
            Thickness  <= '0;
        end else begin
            frame_done <= 1'b0;

            // One-deep request queue; extra requests while pending are dropped.
            if (frame_start && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bank_sel <= ~r_bank_sel;
                        r_pending  <= 1'b0;
                        Thickness  <= thickness_cfg;
                        r_idx      <= '0;
                        r_x_acc    <= X_W'(X_ORIGIN);
                        busy       <= 1'b1;
                        r_state    <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    r_state <= ST_RD1;
                end
                ST_RD1: begin
                    Y0      <= w_y;
                    X0      <= r_x_acc;
                    r_state <= ST_RD2;
                end
                ST_RD2: begin
                    Y1      <= w_y;
                    X1      <= X0 + X_W'(X_STEP);
                    Go      <= 1'b1;
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!Done) begin
                        Go      <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Done) begin
                        if (w_last) begin
                            frame_done <= 1'b1;
                            r_state    <= ST_FIN;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_x_acc <= r_x_acc + X_W'(X_STEP);
                            r_state <= ST_RD0;
                        end
                    end
                end
                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waveform_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_waveform_line_sequencer
//  Brief   : Randomized scoreboard bench with a line-drawer model for
//            waveform_line_sequencer.
//  Revision: 1.0
// ============================================================================
module tb_waveform_line_sequencer;

    localparam int N    = 32;
    localparam int NSEG = N - 1;

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
        int th;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_we = 1'b0;
    logic [4:0] sample_addr = '0;
    logic [7:0] sample_data = '0;
    logic [8:0] thickness_cfg = '0;
    logic       frame_start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       Go;
    logic [8:0] X0;
    logic [8:0] X1;
    logic [7:0] Y0;
    logic [7:0] Y1;
    logic [8:0] Thickness;
    logic       Done = 1'b1;

    waveform_line_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_we     (sample_we),
        .sample_addr   (sample_addr),
        .sample_data   (sample_data),
        .thickness_cfg (thickness_cfg),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .Go            (Go),
        .X0            (X0),
        .X1            (X1),
        .Y0            (Y0),
        .Y1            (Y1),
        .Thickness     (Thickness),
        .Done          (Done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int   m_front [N];
    int   m_back  [N];
    bit   m_busy = 0;
    bit   m_pending = 0;
    bit   accept_next = 0;
    seg_t exp_q [$];
    seg_t e;
    seg_t cur;

    // Drawer / monitor state
    int   frames_done = 0;
    int   seg_in_frame = 0;
    int   line_cyc = 50;
    int   line_cnt = 0;
    int   lat_cnt = 0;
    bit   line_active = 0;
    bit   stab_err = 0;
    bit   chk_busy_rise = 0;
    bit   chk_busy_fall = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int y_of(input int s);
        int v;
        v = 120 - s;
        if (v < 0)   return 0;
        if (v > 239) return 239;
        return v;
    endfunction

    function automatic void accept();
        int tmp;
        seg_t s;
        for (int i = 0; i < N; i++) begin
            tmp        = m_front[i];
            m_front[i] = m_back[i];
            m_back[i]  = tmp;
        end
        for (int i = 0; i < NSEG; i++) begin
            s.x0 = 5 + 10 * i;
            s.x1 = 5 + 10 * (i + 1);
            s.y0 = y_of(m_front[i]);
            s.y1 = y_of(m_front[i + 1]);
            s.th = int'(thickness_cfg);
            exp_q.push_back(s);
        end
        m_busy        = 1;
        lat_cnt       = 0;
        chk_busy_rise = 1;
    endfunction

    // Model update, drawer emulation and output checking, all on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            Done          = 1'b1;
            line_active   = 0;
            seg_in_frame  = 0;
            exp_q.delete();
            m_busy        = 0;
            m_pending     = 0;
            accept_next   = 0;
            chk_busy_rise = 0;
            chk_busy_fall = 0;
        end else begin
            if (chk_busy_rise) begin
                check("busy_rise_after_accept", int'(busy), 1);
                chk_busy_rise = 0;
            end
            if (chk_busy_fall) begin
                check("busy_fall_after_done", int'(busy), 0);
                chk_busy_fall = 0;
            end
            if (m_busy) lat_cnt++;

            if (sample_we) m_back[sample_addr] = int'($signed(sample_data));
            if (accept_next || (frame_start && !m_busy)) begin
                accept_next = 0;
                accept();
            end else if (frame_start) begin
                m_pending = 1;
            end

            if (frame_done) begin
                check("frame_done_when_busy", int'(m_busy), 1);
                check("lines_per_frame", seg_in_frame, NSEG);
                check("queue_empty_at_done", exp_q.size(), 0);
                frames_done++;
                seg_in_frame  = 0;
                m_busy        = 0;
                chk_busy_fall = 1;
                if (m_pending) begin
                    m_pending   = 0;
                    accept_next = 1;
                end
            end

            if (line_active) begin
                if (Go || int'(X0) != cur.x0 || int'(X1) != cur.x1 || int'(Y0) != cur.y0 ||
                    int'(Y1) != cur.y1 || int'(Thickness) != cur.th) stab_err = 1;
                line_cnt--;
                if (line_cnt <= 0) begin
                    Done        = 1'b1;
                    line_active = 0;
                    check("line_go_low_coords_stable", int'(stab_err), 0);
                end
            end else if (Go && Done) begin
                if (seg_in_frame == 0) check("first_go_latency", lat_cnt, 4);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_line: Go with no segment expected, X0=%0d Y0=%0d", X0, Y0);
                end else begin
                    e = exp_q.pop_front();
                    check("seg_X0", int'(X0), e.x0);
                    check("seg_X1", int'(X1), e.x1);
                    check("seg_Y0", int'(Y0), e.y0);
                    check("seg_Y1", int'(Y1), e.y1);
                    check("seg_Thickness", int'(Thickness), e.th);
                end
                cur.x0 = int'(X0);
                cur.x1 = int'(X1);
                cur.y0 = int'(Y0);
                cur.y1 = int'(Y1);
                cur.th = int'(Thickness);
                stab_err     = 0;
                seg_in_frame++;
                Done         = 1'b0;
                line_cnt     = line_cyc;
                line_active  = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp, 1: +127, 2: -128, 3: random
    task automatic load_all(input int mode);
        for (int i = 0; i < N; i++) begin
            tick();
            sample_we   = 1'b1;
            sample_addr = 5'(i);
            case (mode)
                0:       sample_data = 8'(i);
                1:       sample_data = 8'h7F;
                2:       sample_data = 8'h80;
                default: sample_data = 8'($urandom_range(0, 255));
            endcase
        end
        tick();
        sample_we = 1'b0;
    endtask

    task automatic pulse_start();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_completed", frames_done, target);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_Go"}, int'(Go), 0);
        check({tag, "_X0"}, int'(X0), 0);
        check({tag, "_X1"}, int'(X1), 0);
        check({tag, "_Y0"}, int'(Y0), 0);
        check({tag, "_Y1"}, int'(Y1), 0);
        check({tag, "_Thickness"}, int'(Thickness), 0);
    endtask

    initial begin
        int k;
        int snap;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Ramp frame with the 50-cycle drawer
        line_cyc = 50;
        load_all(0);
        tick();
        thickness_cfg = 9'($urandom_range(1, 511));
        pulse_start();
        wait_frames(1, 4000);

        // Positive saturation
        line_cyc = $urandom_range(1, 12);
        load_all(1);
        tick();
        thickness_cfg = 9'($urandom_range(0, 511));
        pulse_start();
        wait_frames(2, 4000);

        // Negative saturation
        load_all(2);
        pulse_start();
        wait_frames(3, 4000);

        // Rewrite during frame plus two extra requests: exactly one more frame
        line_cyc = 50;
        load_all(3);
        thickness_cfg = 9'($urandom_range(0, 511));
        pulse_start();
        k = 0;
        while (seg_in_frame < 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        load_all(3);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_frames(5, 8000);
        snap = frames_done;
        repeat (200) @(negedge clk);
        check("no_extra_frame", frames_done, snap);
        check("idle_after_pending", int'(busy), 0);

        // Sample write coinciding with frame_start lands in the drawn frame
        line_cyc = $urandom_range(1, 8);
        load_all(3);
        tick();
        sample_we     = 1'b1;
        sample_addr   = 5'd7;
        sample_data   = 8'($urandom_range(0, 255));
        thickness_cfg = 9'($urandom_range(0, 511));
        frame_start   = 1'b1;
        tick();
        sample_we   = 1'b0;
        frame_start = 1'b0;
        wait_frames(6, 4000);

        // Reset while segment 10 is in WAIT
        line_cyc = 50;
        load_all(3);
        pulse_start();
        k = 0;
        while (!(seg_in_frame == 11 && line_active && !Go) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("reached_seg10_wait", seg_in_frame, 11);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        reset = 1'b0;

        snap = frames_done;
        line_cyc = $urandom_range(1, 10);
        load_all(3);
        thickness_cfg = 9'($urandom_range(0, 511));
        pulse_start();
        wait_frames(snap + 1, 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/waveform_line_sequencer.md
# waveform_line_sequencer

Frame-level sequencer that sits directly upstream of the thick-line drawer. It holds a double-buffered array of signed audio sample heights. On each frame request it walks the active bank and issues one line segment per adjacent sample pair, (x_i, y_i) → (x_{i+1}, y_{i+1}), using the drawer's Go/Done handshake. Together these segments draw the oscilloscope-style waveform trace into the frame buffer.

## Interface
- NUM_POINTS, 32: samples per frame; power of two, 2..64; segments per frame = NUM_POINTS-1
- X_ORIGIN, 5: x of sample 0 (pixels)
- X_STEP, 10: x spacing between samples; X_ORIGIN + (NUM_POINTS-1)*X_STEP ≤ 319
- Y_CENTER, 120: y of a zero-valued sample
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_we  in  1  write strobe into back bank
- sample_addr  in  log2(NUM_POINTS)  write index
- sample_data  in  8  signed sample, two's complement; positive draws upward
- thickness_cfg  in  9  line thickness, latched at frame start
- frame_start  in  1  one-cycle request: swap banks and draw a frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last segment completes
- Go  out  1  start request to line drawer
- X0, X1  out  9  segment endpoints x
- Y0, Y1  out  8  segment endpoints y
- Thickness  out  9  thickness to line drawer
- Done  in  1  line drawer idle/finished (high when drawer is idle)

## Operation
- Two banks of NUM_POINTS×8. Writes always go to the back bank. Reads always come from the front bank. bank_sel flips on frame acceptance.
- Frame acceptance happens when frame_start is seen (directly or pending) while in IDLE. On acceptance: flip bank_sel, latch thickness_cfg into Thickness, set i=0, go to busy.
- frame_start while busy sets a one-deep pending flag. Further requests while pending are dropped. The pending frame is accepted in the cycle after frame_done.
- Writes during busy are allowed. They land in the back bank and never disturb the frame being drawn.
- Y mapping: y = Y_CENTER − sample, computed in 10-bit signed arithmetic and clamped to [0,239].
- x_i = X_ORIGIN + i*X_STEP, computed in 9 bits by an accumulator (no multiplier).
- States:
  - IDLE: busy=0. Wait for frame_start or pending → RD0.
  - RD0: issue read address i. → RD1.
  - RD1: capture y_i into Y0, x_i into X0. Issue read address i+1. → RD2.
  - RD2: capture y_{i+1} into Y1, X0+X_STEP into X1. → ISSUE.
  - ISSUE: Go=1. Hold Go=1 until Done is sampled low, then → WAIT.
  - WAIT: Go=0. When Done is sampled high: if i=NUM_POINTS-2 → FIN, else i←i+1 → RD0.
  - FIN: frame_done=1 for one cycle. → IDLE.
- X0/X1/Y0/Y1/Thickness are held stable from entry into ISSUE until exit from WAIT. The drawer reads them combinationally throughout the line.

## Timing
- Reset values: busy=0, frame_done=0, Go=0, X0=X1=0, Y0=Y1=0, Thickness=0, bank_sel=0, pending=0, state IDLE. Bank contents are undefined after reset.
- Bank read latency is one cycle (synchronous read).
- frame_start in IDLE: busy rises on the next edge. The first Go is asserted 3 cycles after acceptance (RD0, RD1, RD2, then ISSUE).
- Go is never asserted while Done=0 except during the acceptance overlap. Go is always deasserted before the drawer can return to idle, so one Go produces exactly one line.
- Per-segment overhead: 4 cycles plus the drawer's line time.
- A sample write and frame_start in the same cycle: the write goes to the pre-swap back bank. That bank becomes the front bank, so the write is included in the frame.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The pending request is lost. The drawer is reset by the same signal.
- A Done glitch high during ISSUE is ignored. Only the low→high sequence observed across ISSUE→WAIT counts.

## Structure
- vis_pkg: SCREEN_W=320, SCREEN_H=240, coordinate widths (X 9 bits, Y 8 bits), and the state enum shared with other visualizer sequencers.
- One sub-module: sample_bank_ram. This is a dual-bank, one-write/one-read, synchronous-read RAM with a bank_sel input.
- Also contained in this block: the FSM, the x accumulator, and the y mapping/clamp.

## Test plan
- Load ramp samples 0..31 (s_i=i), then frame_start. Expect 31 Go handshakes with X0=5+10i, X1=X0+10, Y0=120−i, Y1=119−i, then one frame_done pulse with busy falling.
- Load s=+127 everywhere with Y_CENTER=120: Y0=Y1=0 (clamped). Load s=−128 everywhere: Y=239 (clamped, since 120+128=248 exceeds 239).
- Drawer model holds Done low for 50 cycles per line. Check Go is held until Done falls, coordinates stay stable throughout, and there are exactly 31 lines.
- Assert frame_start twice more while busy. Expect exactly one extra frame to start the cycle after frame_done, then return to IDLE.
- Rewrite all samples while frame 1 is drawing. Expect frame 1 to use the old values and frame 2 to use the new values.
- Assert reset during the WAIT state of segment 10. Expect busy=0, Go=0, all coordinates 0 immediately; a new frame_start after reset draws from segment 0.
